// File: rtl/pong_game_controller_if.sv
// Player inputs and renderer-facing game state for the Pong controller.
// The slave modport is the controller and the master modport is whoever drives the buttons.
interface pong_game_controller_if;
  logic       frame_tick;
  logic       start;
  logic       left_up;
  logic       left_down;
  logic       right_up;
  logic       right_down;
  logic [9:0] ball_loc_x;
  logic [9:0] ball_loc_y;
  logic [9:0] left_paddle_loc;
  logic [9:0] right_paddle_loc;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       game_over;
  logic [1:0] state;

  modport master (
    output frame_tick, start, left_up, left_down, right_up, right_down,
    input  ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc,
    input  left_score, right_score, game_over, state
  );

  modport slave (
    input  frame_tick, start, left_up, left_down, right_up, right_down,
    output ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc,
    output left_score, right_score, game_over, state
  );
endinterface

// File: rtl/pong_game_controller.sv
// Pong game sequencer: serve pause, ball and paddle motion, collisions, scoring and win detection.
// Objects advance once per frame_tick, so the outputs stay stable while the renderer scans out.
module pong_game_controller #(
  parameter int FIELD_X_BEGIN = 20,
  parameter int FIELD_X_END   = 619,
  parameter int FIELD_Y_BEGIN = 20,
  parameter int FIELD_Y_END   = 459,
  parameter int PADDLE_H      = 48,
  parameter int PADDLE_W      = 8,
  parameter int PADDLE_GAP    = 8,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int PADDLE_SPEED  = 4,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_FRAMES  = 60
) (
  input logic clk,
  input logic reset,
  pong_game_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam int LPX  = FIELD_X_BEGIN + PADDLE_GAP;
  localparam int RPX  = FIELD_X_END - PADDLE_GAP - PADDLE_W + 1;
  localparam int CX   = (FIELD_X_BEGIN + FIELD_X_END + 1) / 2 - BALL_SIZE / 2;
  localparam int CY   = (FIELD_Y_BEGIN + FIELD_Y_END + 1) / 2 - BALL_SIZE / 2;
  localparam int PC   = (FIELD_Y_BEGIN + FIELD_Y_END + 1) / 2 - PADDLE_H / 2;
  localparam int PMAX = FIELD_Y_END + 1 - PADDLE_H;
  localparam int CW   = $clog2(SERVE_FRAMES + 1);

  localparam logic signed [11:0] K_SPD = 12'(BALL_SPEED);
  localparam logic signed [11:0] K_BS  = 12'(BALL_SIZE);
  localparam logic signed [11:0] K_PH  = 12'(PADDLE_H);
  localparam logic signed [11:0] K_LF  = 12'(LPX + PADDLE_W);
  localparam logic signed [11:0] K_RPX = 12'(RPX);
  localparam logic signed [11:0] K_FX0 = 12'(FIELD_X_BEGIN);
  localparam logic signed [11:0] K_FX1 = 12'(FIELD_X_END);
  localparam logic signed [11:0] K_FY0 = 12'(FIELD_Y_BEGIN);
  localparam logic signed [11:0] K_FY1 = 12'(FIELD_Y_END);

  state_t          state_reg, state_next;
  logic [9:0]      bx_reg, bx_next, by_reg, by_next;
  logic [9:0]      lp_reg, lp_next, rp_reg, rp_next;
  logic [3:0]      ls_reg, ls_next, rs_reg, rs_next;
  logic            dir_x_reg, dir_x_next;  // 1 = moving right
  logic            dir_y_reg, dir_y_next;  // 1 = moving down
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic signed [11:0] bx_s, by_s, lp_s, rp_s, nx, ny;
  logic               v_l, v_r, hit_l, hit_r, score_l, score_r;

  function automatic logic [9:0] paddle_step(input logic [9:0] loc, input logic up, input logic down);
    paddle_step = loc;
    if (up && !down)
      paddle_step = ({1'b0, loc} < 11'(FIELD_Y_BEGIN + PADDLE_SPEED)) ? 10'(FIELD_Y_BEGIN)
                                                                     : 10'({1'b0, loc} - 11'(PADDLE_SPEED));
    else if (down && !up)
      paddle_step = ({1'b0, loc} + 11'(PADDLE_SPEED) > 11'(PMAX)) ? 10'(PMAX)
                                                                 : 10'({1'b0, loc} + 11'(PADDLE_SPEED));
  endfunction

  assign bx_s = signed'({2'b00, bx_reg});
  assign by_s = signed'({2'b00, by_reg});
  assign lp_s = signed'({2'b00, lp_reg});
  assign rp_s = signed'({2'b00, rp_reg});
  assign nx   = dir_x_reg ? bx_s + K_SPD : bx_s - K_SPD;
  assign ny   = dir_y_reg ? by_s + K_SPD : by_s - K_SPD;

  // Collision tests use the paddle positions from before this frame's paddle move.
  assign v_l     = (by_s + K_BS - 12'sd1 >= lp_s) && (by_s <= lp_s + K_PH - 12'sd1);
  assign v_r     = (by_s + K_BS - 12'sd1 >= rp_s) && (by_s <= rp_s + K_PH - 12'sd1);
  assign hit_l   = !dir_x_reg && (bx_s >= K_LF) && (nx <= K_LF - 12'sd1) && v_l;
  assign hit_r   = dir_x_reg && (bx_s + K_BS - 12'sd1 <= K_RPX - 12'sd1) &&
                   (nx + K_BS - 12'sd1 >= K_RPX) && v_r;
  assign score_r = !dir_x_reg && !hit_l && (nx < K_FX0);
  assign score_l = dir_x_reg && !hit_r && (nx + K_BS - 12'sd1 > K_FX1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      bx_reg    <= 10'(CX);
      by_reg    <= 10'(CY);
      lp_reg    <= 10'(PC);
      rp_reg    <= 10'(PC);
      ls_reg    <= '0;
      rs_reg    <= '0;
      dir_x_reg <= 1'b1;
      dir_y_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bx_reg    <= bx_next;
      by_reg    <= by_next;
      lp_reg    <= lp_next;
      rp_reg    <= rp_next;
      ls_reg    <= ls_next;
      rs_reg    <= rs_next;
      dir_x_reg <= dir_x_next;
      dir_y_reg <= dir_y_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bx_next    = bx_reg;
    by_next    = by_reg;
    lp_next    = lp_reg;
    rp_next    = rp_reg;
    ls_next    = ls_reg;
    rs_next    = rs_reg;
    dir_x_next = dir_x_reg;
    dir_y_next = dir_y_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: if (bus.start) begin
        state_next = SERVE;
        cnt_next   = '0;
      end
      SERVE: if (bus.frame_tick) begin
        lp_next  = paddle_step(lp_reg, bus.left_up, bus.left_down);
        rp_next  = paddle_step(rp_reg, bus.right_up, bus.right_down);
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(SERVE_FRAMES - 1)) state_next = PLAY;
      end
      PLAY: if (bus.frame_tick) begin
        lp_next = paddle_step(lp_reg, bus.left_up, bus.left_down);
        rp_next = paddle_step(rp_reg, bus.right_up, bus.right_down);
        if (ny + K_BS - 12'sd1 >= K_FY1) begin
          by_next    = 10'(FIELD_Y_END - BALL_SIZE + 1);
          dir_y_next = 1'b0;
        end else if (ny <= K_FY0) begin
          by_next    = 10'(FIELD_Y_BEGIN);
          dir_y_next = 1'b1;
        end else begin
          by_next = ny[9:0];
        end
        if (hit_l) begin
          bx_next    = 10'(LPX + PADDLE_W);
          dir_x_next = 1'b1;
        end else if (hit_r) begin
          bx_next    = 10'(RPX - BALL_SIZE);
          dir_x_next = 1'b0;
        end else begin
          bx_next = nx[9:0];
        end
        // A point recentres the ball and serves it toward the player who conceded.
        if (score_l || score_r) begin
          bx_next    = 10'(CX);
          by_next    = 10'(CY);
          dir_x_next = score_l;
          dir_y_next = 1'b1;
          cnt_next   = '0;
          if (score_l) begin
            ls_next    = ls_reg + 4'd1;
            state_next = (ls_reg + 4'd1 == 4'(WIN_SCORE)) ? OVER : SERVE;
          end else begin
            rs_next    = rs_reg + 4'd1;
            state_next = (rs_reg + 4'd1 == 4'(WIN_SCORE)) ? OVER : SERVE;
          end
        end
      end
      OVER: if (bus.start) begin
        state_next = SERVE;
        bx_next    = 10'(CX);
        by_next    = 10'(CY);
        lp_next    = 10'(PC);
        rp_next    = 10'(PC);
        ls_next    = '0;
        rs_next    = '0;
        dir_x_next = 1'b1;
        dir_y_next = 1'b1;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    bus.ball_loc_x       = bx_reg;
    bus.ball_loc_y       = by_reg;
    bus.left_paddle_loc  = lp_reg;
    bus.right_paddle_loc = rp_reg;
    bus.left_score       = ls_reg;
    bus.right_score      = rs_reg;
    bus.game_over        = (state_reg == OVER);
    bus.state            = state_reg;
  end
endmodule
